byte_write_dual_ram: RTL and testbench

Simple dual-port RAM (one write port, one read port, one clock) with per-byte write enables, selectable read latency, selectable read-during-write behaviour and an optional hardware clear sweep after reset. It is the general-purpose successor to the single-port RAM and is intended for frame buffers, FIFOs and register files that need independent read and write addresses. The memory array carries no reset, so block-RAM inference is preserved. Only the control path and the output registers are reset.

---
 rtl/byte_write_dual_ram.sv | 128 ++++++++++++
 tb/tb_byte_write_dual_ram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_write_dual_ram.sv
// Simple dual-port RAM with byte write strobes and an optional post-reset zeroing sweep.
// Read data appears READ_LATENCY cycles after issue. There is no backpressure: one read and one write are accepted per cycle once busy drops.
module byte_write_dual_ram #(
   parameter int WIDTH          = 8,
   parameter int ENTRIES        = 16,
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int AW            = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
   localparam int BYTES         = WIDTH / BYTE_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   input  logic [AW-1:0]     write_address,
   input  logic [WIDTH-1:0]  write_data,
   input  logic [BYTES-1:0]  write_enable,
   input  logic [AW-1:0]     read_address,
   input  logic              read_enable,
   output logic [WIDTH-1:0]  read_data,
   output logic              read_valid
);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_cnt;
   logic [BYTES-1:0]  mem_we;
   logic [AW-1:0]     mem_addr;
   logic [WIDTH-1:0]  mem_wdat;
   logic              wr_addr_ok, rd_addr_ok, rd_issue, collide;
   logic [WIDTH-1:0]  rd_word;
   logic              s1_vld;
   logic [WIDTH-1:0]  s1_dat;

   // No reset on the array so it still maps onto block RAM.
   logic [WIDTH-1:0]  mem [ENTRIES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && clr_cnt == AW'(ENTRIES - 1))
         state_nxt = READY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 clr_cnt <= '0;
      else if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
   end

   assign wr_addr_ok = {1'b0, write_address} < (AW+1)'(ENTRIES);
   assign rd_addr_ok = {1'b0, read_address}  < (AW+1)'(ENTRIES);

   // The sweep owns the single write port while it runs.
   always_comb begin
      busy     = (state == CLEAR);
      mem_we   = '0;
      mem_addr = clr_cnt;
      mem_wdat = '0;
      if (state == CLEAR) begin
         mem_we = '1;
      end else if (wr_addr_ok) begin
         mem_we   = write_enable;
         mem_addr = write_address;
         mem_wdat = write_data;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTES; i++)
         if (mem_we[i])
            mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
   end

   assign rd_issue = read_enable && !busy;
   assign collide  = (WRITE_FIRST != 0) && !busy && wr_addr_ok && (write_address == read_address);

   // Write-first merges the incoming bytes over the stored word rather than trusting array semantics.
   always_comb begin
      rd_word = '0;
      if (rd_addr_ok) begin
         rd_word = mem[read_address];
         if (collide)
            for (int i = 0; i < BYTES; i++)
               if (write_enable[i])
                  rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else begin
         s1_vld <= rd_issue;
         if (rd_issue) s1_dat <= rd_word;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic             s2_vld;
         logic [WIDTH-1:0] s2_dat;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_vld <= 1'b0;
               s2_dat <= '0;
            end else begin
               s2_vld <= s1_vld;
               if (s1_vld) s2_dat <= s1_dat;
            end
         end

         assign read_valid = s2_vld;
         assign read_data  = s2_dat;
      end else begin : g_lat1
         assign read_valid = s1_vld;
         assign read_data  = s1_dat;
      end
   endgenerate

endmodule

// File: tb/tb_byte_write_dual_ram.sv
// Bench for byte_write_dual_ram: two instances (16 deep read-first latency 1, 10 deep write-first latency 2)
// share one stimulus stream; a reference model feeds per-instance expectation queues.
module tb_byte_write_dual_ram;

   logic        clk, rst;
   logic [3:0]  wa, ra, we;
   logic [31:0] wd;
   logic        re;
   logic        busy_a, rv_a, busy_b, rv_b;
   logic [31:0] rd_a, rd_b;

   typedef struct {
      int          due;
      logic [31:0] dat;
   } exp_t;

   exp_t        qa[$], qb[$];
   logic [31:0] ma[16];
   logic [31:0] mb[10];
   int          cyc, n_cmp, n_bad;

   byte_write_dual_ram #(.WIDTH(32), .ENTRIES(16), .BYTE_WIDTH(8), .READ_LATENCY(1),
                         .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut_a (
      .clk(clk), .rst(rst), .busy(busy_a),
      .write_address(wa), .write_data(wd), .write_enable(we),
      .read_address(ra), .read_enable(re),
      .read_data(rd_a), .read_valid(rv_a));

   byte_write_dual_ram #(.WIDTH(32), .ENTRIES(10), .BYTE_WIDTH(8), .READ_LATENCY(2),
                         .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut_b (
      .clk(clk), .rst(rst), .busy(busy_b),
      .write_address(wa), .write_data(wd), .write_enable(we),
      .read_address(ra), .read_enable(re),
      .read_data(rd_b), .read_valid(rv_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] en);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (en[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rv_a === 1'b1) begin
         if (qa.size() == 0) chk("a_spurious_valid", {31'b0, rv_a}, 32'd0);
         else begin
            e = qa.pop_front();
            chk("a_data", rd_a, e.dat);
            chk("a_latency", cyc, e.due);
         end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
         e = qa.pop_front();
         chk("a_missing_valid", {31'b0, rv_a}, 32'd1);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rv_b === 1'b1) begin
         if (qb.size() == 0) chk("b_spurious_valid", {31'b0, rv_b}, 32'd0);
         else begin
            e = qb.pop_front();
            chk("b_data", rd_b, e.dat);
            chk("b_latency", cyc, e.due);
         end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
         e = qb.pop_front();
         chk("b_missing_valid", {31'b0, rv_b}, 32'd1);
      end
   end

   task automatic step(input logic [3:0] w_en, input logic [3:0] w_a, input logic [31:0] w_d,
                       input logic r_en, input logic [3:0] r_a);
      exp_t e;
      @(negedge clk);
      we = w_en; wa = w_a; wd = w_d; re = r_en; ra = r_a;
      if (r_en) begin
         e.due = cyc + 1;
         e.dat = ma[r_a];
         qa.push_back(e);
         e.due = cyc + 2;
         e.dat = 32'd0;
         if (r_a < 10) begin
            e.dat = mb[r_a];
            if (w_a == r_a) e.dat = merge(mb[r_a], w_d, w_en);
         end
         qb.push_back(e);
      end
      ma[w_a] = merge(ma[w_a], w_d, w_en);
      if (w_a < 10) mb[w_a] = merge(mb[w_a], w_d, w_en);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy_a"}, {31'b0, busy_a}, 32'd1);
      chk({tag, "_busy_b"}, {31'b0, busy_b}, 32'd1);
      chk({tag, "_rv_a"},   {31'b0, rv_a},   32'd0);
      chk({tag, "_rv_b"},   {31'b0, rv_b},   32'd0);
      chk({tag, "_rd_a"},   rd_a,            32'd0);
      chk({tag, "_rd_b"},   rd_b,            32'd0);
   endtask

   // Called at the negedge where rst has just dropped; junk traffic is offered while both sweep.
   task automatic sweep_check(input string tag);
      int na, nb;
      na = 0; nb = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy_a) na++;
         if (busy_b) nb++;
         if (!busy_a && !busy_b) break;
         if (busy_b) begin
            we = 4'hF; wa = i[3:0]; wd = 32'hDEADBEEF; re = 1'b1; ra = i[3:0];
         end else begin
            we = 4'h0; re = 1'b0;
         end
         @(negedge clk);
      end
      we = 4'h0; re = 1'b0;
      chk({tag, "_busy_cycles_a"}, na, 32'd16);
      chk({tag, "_busy_cycles_b"}, nb, 32'd10);
      for (int i = 0; i < 16; i++) ma[i] = 32'd0;
      for (int i = 0; i < 10; i++) mb[i] = 32'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; we = 4'h0; wa = 4'h0; wd = 32'h0; re = 1'b0; ra = 4'h0;
      repeat (3) @(negedge clk);
      check_reset_values("por");
      rst = 1'b0;
      sweep_check("por");

      // Everything reads back zero after the sweep, including out-of-range rows of the short RAM.
      for (int i = 0; i < 16; i++) step(4'h0, 4'h0, 32'h0, 1'b1, i[3:0]);
      idle(3);

      step(4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
      step(4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0);
      step(4'h0, 4'd0, 32'h0,        1'b1, 4'd3);
      idle(2);
      chk("byte_merge_model", ma[3], 32'hAA22CC44);

      step(4'hF, 4'd7, 32'h0000000F, 1'b0, 4'd0);
      step(4'hF, 4'd7, 32'h00000055, 1'b1, 4'd7);
      step(4'h0, 4'd0, 32'h0,        1'b1, 4'd7);
      step(4'h2, 4'd7, 32'h0000AA00, 1'b1, 4'd7);
      step(4'h0, 4'd0, 32'h0,        1'b1, 4'd7);
      idle(3);

      step(4'hF, 4'd0, 32'h10, 1'b0, 4'd0);
      step(4'hF, 4'd1, 32'h11, 1'b0, 4'd0);
      step(4'hF, 4'd2, 32'h12, 1'b0, 4'd0);
      step(4'h0, 4'd0, 32'h0,  1'b1, 4'd0);
      step(4'h0, 4'd0, 32'h0,  1'b1, 4'd1);
      step(4'h0, 4'd0, 32'h0,  1'b1, 4'd2);
      idle(3);

      step(4'hF, 4'd12, 32'h99, 1'b0, 4'd0);
      step(4'h0, 4'd0,  32'h0,  1'b1, 4'd12);
      for (int i = 0; i < 10; i++) step(4'h0, 4'h0, 32'h0, 1'b1, i[3:0]);
      step(4'hF, 4'd4, 32'h44444444, 1'b1, 4'd5);
      step(4'hF, 4'd5, 32'h55555555, 1'b1, 4'd4);
      idle(3);

      for (int i = 0; i < 60; i++) begin
         logic [3:0] a, b;
         a = 4'($urandom_range(0, 15));
         b = ($urandom_range(0, 1) == 1) ? a : 4'($urandom_range(0, 15));
         step(4'($urandom_range(0, 15)), a, $urandom, 1'($urandom_range(0, 1)), b);
      end
      idle(4);

      // A read in flight when reset hits must never complete.
      step(4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
      @(posedge clk);
      #1;
      rst = 1'b1; re = 1'b0;
      qa.delete(); qb.delete();
      repeat (2) @(negedge clk);
      check_reset_values("midread");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("midsweep_busy_a", {31'b0, busy_a}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("midsweep");
      rst = 1'b0;
      sweep_check("resweep");
      for (int i = 0; i < 16; i += 3) step(4'h0, 4'h0, 32'h0, 1'b1, i[3:0]);
      idle(4);
      chk("drain_a", qa.size(), 32'd0);
      chk("drain_b", qb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
